// File: rtl/seq_subtractor.sv
// seq_subtractor: multi-cycle wide subtractor, CHUNK bits per clock.
// Borrow ripples between chunks through a carry register.
module seq_subtractor #(
    parameter int WIDTH = 1028,
    parameter int CHUNK = 257
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] reg_a_q, reg_a_d;
    logic [WIDTH-1:0] reg_b_q, reg_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             c_q, c_d;
    logic             borrow_q, borrow_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sum;

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            result_q <= '0;
            idx_q    <= '0;
            c_q      <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            c_q      <= c_d;
            borrow_q <= borrow_d;
        end
    end

    // Next-state logic plus one CHUNK-wide a + ~b + c step per RUN cycle.
    always_comb begin
        state_d  = state_q;
        reg_a_d  = reg_a_q;
        reg_b_d  = reg_b_q;
        result_d = result_q;
        idx_d    = idx_q;
        c_d      = c_q;
        borrow_d = borrow_q;
        a_chunk  = reg_a_q[idx_q*CHUNK +: CHUNK];
        b_chunk  = reg_b_q[idx_q*CHUNK +: CHUNK];
        sum      = {1'b0, a_chunk} + {1'b0, ~b_chunk}
                 + {{CHUNK{1'b0}}, c_q};
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    reg_a_d = in_a;
                    reg_b_d = in_b;
                    idx_d   = '0;
                    c_d     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[idx_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
                c_d   = sum[CHUNK];
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(N - 1)) begin
                    borrow_d = ~sum[CHUNK];
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_seq_subtractor.sv
// tb_seq_subtractor: directed checks of seq_subtractor.
// Expected values are hand-derived constants.
module tb_seq_subtractor;

    localparam int W = 1028;

    logic         clk;
    logic         resetn;
    logic         start;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         borrow;

    int tests;
    int fails;

    seq_subtractor #(
        .WIDTH(1028),
        .CHUNK(257)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .start (start),
        .in_a  (in_a),
        .in_b  (in_b),
        .busy  (busy),
        .done  (done),
        .result(result),
        .borrow(borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs_lo=%h exp_lo=%h obs_hi=%h exp_hi=%h",
                   tag, obs[63:0], exp[63:0],
                   obs[W-1:W-64], exp[W-1:W-64]);
        end
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_done"}, W'(done), W'(1));
    endtask

    task automatic run_op(input string tag,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic [W-1:0] er,
                          input logic eb);
        int cyc;
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy0"}, W'(busy), W'(1));
        wait_done(tag, cyc);
        chk({tag, "_lat"}, W'(cyc), W'(4));
        chk({tag, "_res"}, result, er);
        chk({tag, "_brw"}, W'(borrow), W'(eb));
        chk({tag, "_busyd"}, W'(busy), W'(1));
        tick();
        chk({tag, "_pulse"}, W'(done), W'(0));
        chk({tag, "_idle"}, W'(busy), W'(0));
        chk({tag, "_hold"}, result, er);
    endtask

    initial begin
        logic [W-1:0] r;
        logic [W-1:0] ones;
        logic [W-1:0] one;
        int           cyc;
        int           npulse;
        int           t_first;
        int           t_second;
        int           prev_done;

        tests  = 0;
        fails  = 0;
        resetn = 1'b0;
        start  = 1'b0;
        in_a   = '0;
        in_b   = '0;
        ones   = '1;
        one    = W'(1);

        tick();
        tick();
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_res", result, '0);
        chk("rst_brw", W'(borrow), W'(0));
        resetn = 1'b1;

        run_op("basic", W'(5), W'(3), W'(2), 1'b0);
        run_op("neg", W'(3), W'(5), ones ^ one, 1'b1);
        run_op("chk1", one << 257, one, (one << 257) - one, 1'b0);
        run_op("chk3", one << 771, one, (one << 771) - one, 1'b0);

        r = '0;
        for (int i = 0; i < 33; i++) r = (r << 32) | W'($urandom());
        run_op("eq", r, r, '0, 1'b0);
        run_op("max_a", ones, '0, ones, 1'b0);
        run_op("max_b", '0, ones, one, 1'b1);

        // second start while busy is ignored; in_a changes after E0
        in_a  = W'(100);
        in_b  = W'(30);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        in_a  = W'(7);
        in_b  = W'(9);
        start = 1'b1;
        tick();
        start = 1'b0;
        in_a  = W'(55);
        wait_done("ign", cyc);
        chk("ign_lat", W'(cyc), W'(2));
        chk("ign_res", result, W'(70));
        chk("ign_brw", W'(borrow), W'(0));
        npulse = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy || done) npulse++;
        end
        chk("ign_noop", W'(npulse), W'(0));

        // start held high: back-to-back ops six cycles apart
        in_a      = W'(10);
        in_b      = W'(4);
        start     = 1'b1;
        npulse    = 0;
        t_first   = -1;
        t_second  = -1;
        prev_done = 0;
        tick();
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done && prev_done == 1) npulse += 10;
            prev_done = done ? 1 : 0;
            if (done) begin
                npulse++;
                if (t_first < 0) begin
                    t_first = i;
                    chk("b2b_res1", result, W'(6));
                    chk("b2b_brw1", W'(borrow), W'(0));
                    in_a = W'(20);
                    in_b = W'(25);
                end else begin
                    t_second = i;
                    start = 1'b0;
                    chk("b2b_res2", result, ones - W'(4));
                    chk("b2b_brw2", W'(borrow), W'(1));
                end
            end
        end
        start = 1'b0;
        chk("b2b_n", W'(npulse), W'(2));
        chk("b2b_t1", W'(t_first), W'(4));
        chk("b2b_t2", W'(t_second), W'(10));
        chk("b2b_idle", W'(busy), W'(0));

        // reset between E2 and E3 after a borrow=1 result
        in_a  = ones;
        in_b  = W'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid_part", W'(result != '0), W'(1));
        resetn = 1'b0;
        #1;
        chk("mid_busy", W'(busy), W'(0));
        chk("mid_done", W'(done), W'(0));
        chk("mid_res", result, '0);
        chk("mid_brw", W'(borrow), W'(0));
        tick();
        resetn = 1'b1;
        npulse = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) npulse++;
        end
        chk("mid_nodone", W'(npulse), W'(0));
        run_op("post", W'(1000), W'(1), W'(999), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
